// File: rtl/gpio_irq_ctrl_pkg.sv
// Shared types and register map for the GPIO interrupt priority controller.
package gpio_irq_ctrl_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StReq   = 2'd1,
    StInsvc = 2'd2
  } state_e;

  localparam logic [1:0] ADDR_PENDING = 2'd0;
  localparam logic [1:0] ADDR_MASK    = 2'd1;
  localparam logic [1:0] ADDR_TRIG    = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  localparam int unsigned EOI_BIT = 0;

endpackage

// File: rtl/gpio_irq_priority_ctrl_if.sv
// Avalon-style configuration bus plus CPU interrupt handshake.
interface gpio_irq_priority_ctrl_if #(
  parameter int unsigned VEC_W = 5
);
  logic [1:0]       address;
  logic             chipselect;
  logic             write_n;
  logic [31:0]      writedata;
  logic [31:0]      readdata;
  logic             cpu_irq;
  logic [VEC_W-1:0] cpu_irq_vec;
  logic             cpu_irq_ack;

  modport slave (
    input  address, chipselect, write_n, writedata, cpu_irq_ack,
    output readdata, cpu_irq, cpu_irq_vec
  );

  modport master (
    output address, chipselect, write_n, writedata, cpu_irq_ack,
    input  readdata, cpu_irq, cpu_irq_vec
  );
endinterface

// File: rtl/irq_prio_select.sv
// Combinational priority picker: first set request found searching upward from start, wrapping.
module irq_prio_select #(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned VEC_W   = 5
) (
  input  logic [NUM_SRC-1:0] req,
  input  logic [VEC_W-1:0]   start,
  output logic [VEC_W-1:0]   winner,
  output logic               any
);

  always_comb begin
    int idx;
    logic [NUM_SRC-1:0] rot;
    idx    = 0;
    rot    = '0;
    winner = '0;
    any    = 1'b0;
    // Walk from the furthest offset down so the closest match to start is the last one kept.
    for (int i = int'(NUM_SRC) - 1; i >= 0; i--) begin
      idx = int'(start) + i;
      if (idx >= int'(NUM_SRC)) idx = idx - int'(NUM_SRC);
      rot = req >> idx;
      if (rot[0]) begin
        winner = VEC_W'(idx);
        any    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/gpio_irq_priority_ctrl.sv
// Masks, latches and arbitrates GPIO interrupt lines and holds the winner in service until EOI.
// Define IRQ_ROUND_ROBIN_EN for rotating priority; otherwise the lowest index always wins.
module gpio_irq_priority_ctrl
  import gpio_irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC = 8,
  parameter int unsigned VEC_W   = 5
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC-1:0]       irq_src,
  gpio_irq_priority_ctrl_if.slave  bus
);

  logic [NUM_SRC-1:0] src_q, src_q2;
  logic [NUM_SRC-1:0] edge_pend_q, edge_pend_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] trig_q, trig_d;
  logic [NUM_SRC-1:0] pending, req, vec_onehot, w1c, ack_clr;
  state_e             state_q, state_d;
  logic [VEC_W-1:0]   vec_q, vec_d;
  logic [VEC_W-1:0]   start, winner;
  logic               any;
  logic               cpu_irq_q, cpu_irq_d;
  logic [31:0]        readdata_q, readdata_d;
  logic [4:0]         vec_field;
  logic               wr, eoi, ack_ok;
  logic               unused_wdata;

  assign unused_wdata = ^bus.writedata;

  assign wr         = bus.chipselect & ~bus.write_n;
  assign eoi        = wr && (bus.address == ADDR_STATUS) && bus.writedata[EOI_BIT];
  assign ack_ok     = (state_q == StReq) && bus.cpu_irq_ack;
  assign vec_onehot = NUM_SRC'(1'b1) << vec_q;
  assign w1c        = (wr && (bus.address == ADDR_PENDING)) ? bus.writedata[NUM_SRC-1:0] : '0;
  assign ack_clr    = ack_ok ? vec_onehot : '0;

  // Masking with trig_q keeps a freshly switched edge source starting from zero.
  assign edge_pend_d = trig_q & ((edge_pend_q & ~(w1c | ack_clr)) | (src_q & ~src_q2));
  assign pending     = (trig_q & edge_pend_q) | (~trig_q & src_q);
  assign req         = pending & mask_q;

  assign mask_d = (wr && (bus.address == ADDR_MASK)) ? bus.writedata[NUM_SRC-1:0] : mask_q;
  assign trig_d = (wr && (bus.address == ADDR_TRIG)) ? bus.writedata[NUM_SRC-1:0] : trig_q;

`ifdef IRQ_ROUND_ROBIN_EN
  logic [VEC_W-1:0] rr_ptr_q, rr_ptr_d;

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (ack_ok) begin
      rr_ptr_d = (int'(vec_q) == int'(NUM_SRC) - 1) ? '0 : vec_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) rr_ptr_q <= '0;
    else       rr_ptr_q <= rr_ptr_d;
  end

  assign start = rr_ptr_q;
`else
  assign start = '0;
`endif

  irq_prio_select #(
    .NUM_SRC (NUM_SRC),
    .VEC_W   (VEC_W)
  ) u_select (
    .req    (req),
    .start  (start),
    .winner (winner),
    .any    (any)
  );

  always_comb begin
    state_d   = state_q;
    vec_d     = vec_q;
    cpu_irq_d = cpu_irq_q;
    unique case (state_q)
      StIdle: begin
        if (any) begin
          state_d   = StReq;
          vec_d     = winner;
          cpu_irq_d = 1'b1;
        end
      end
      StReq: begin
        // Ack takes precedence over a request withdrawn in the same cycle.
        if (bus.cpu_irq_ack) begin
          state_d   = StInsvc;
          cpu_irq_d = 1'b0;
        end else if (~|(req & vec_onehot)) begin
          state_d   = StIdle;
          cpu_irq_d = 1'b0;
        end
      end
      StInsvc: begin
        if (eoi) state_d = StIdle;
      end
      default: begin
        state_d   = StIdle;
        cpu_irq_d = 1'b0;
      end
    endcase
  end

  assign vec_field = 5'(vec_q);

  always_comb begin
    readdata_d = '0;
    unique case (bus.address)
      ADDR_PENDING: readdata_d = 32'(pending);
      ADDR_MASK:    readdata_d = 32'(mask_q);
      ADDR_TRIG:    readdata_d = 32'(trig_q);
      ADDR_STATUS:  readdata_d = {23'b0, state_q, 2'b0, vec_field};
      default:      readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q       <= '0;
      src_q2      <= '0;
      edge_pend_q <= '0;
      mask_q      <= '0;
      trig_q      <= '0;
      state_q     <= StIdle;
      vec_q       <= '0;
      cpu_irq_q   <= 1'b0;
      readdata_q  <= '0;
    end else begin
      src_q       <= irq_src;
      src_q2      <= src_q;
      edge_pend_q <= edge_pend_d;
      mask_q      <= mask_d;
      trig_q      <= trig_d;
      state_q     <= state_d;
      vec_q       <= vec_d;
      cpu_irq_q   <= cpu_irq_d;
      readdata_q  <= readdata_d;
    end
  end

  assign bus.readdata    = readdata_q;
  assign bus.cpu_irq     = cpu_irq_q;
  assign bus.cpu_irq_vec = vec_q;

endmodule
